// File: rtl/countdown_timer.sv
// Retriggerable single-shot delay timer: Done rises COUNT cycles after Start is
// first sampled low, and stays high until the next Start or Reset.
//
// state | meaning
// IDLE  | never started, or reset; counter 0
// LOAD  | Start held high; counter parked at COUNT
// RUN   | counting down after Start fell
// DONE  | delay elapsed; Done sticky, counter 0
module countdown_timer #(
  parameter int COUNT = 300
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Start,
  output logic                             Done,
  output logic                             Busy,
  output logic [$clog2(COUNT+1)-1:0]       Remaining
);

  localparam int WIDTH = $clog2(COUNT + 1);
  localparam logic [WIDTH-1:0] COUNT_W    = WIDTH'(COUNT);
  localparam logic [WIDTH-1:0] COUNT_M1_W = WIDTH'(COUNT - 1);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);

  if (COUNT < 1) begin : g_bad_count
    $error("countdown_timer: COUNT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             done_q;
  logic             busy_q;

  // Done/Busy are registered alongside the state so no path exists from Start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (Start) begin
      state_q <= LOAD;
      cnt_q   <= COUNT_W;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (COUNT == 1) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RUN;
            cnt_q   <= COUNT_M1_W;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q > ONE_W) begin
            cnt_q <= cnt_q - ONE_W;
          end else begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= state_q;
          cnt_q   <= cnt_q;
        end
      endcase
    end
  end

  assign Done      = done_q;
  assign Busy      = busy_q;
  assign Remaining = cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: COUNT=300 and COUNT=1 instances share stimulus and
// are compared every cycle against an elapsed-cycles model.
module tb_countdown_timer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       done_a, busy_a, done_b, busy_b;
  logic [8:0] rem_a;
  logic [0:0] rem_b;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles elapsed since Start was last sampled high, per instance.
  int  counts [2] = '{300, 1};
  int  elapsed[2] = '{0, 0};
  bit  armed  [2] = '{1'b0, 1'b0};

  always #5 Clk = ~Clk;

  countdown_timer #(.COUNT(300)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Done(done_a), .Busy(busy_a), .Remaining(rem_a)
  );

  countdown_timer #(.COUNT(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Done(done_b), .Busy(busy_b), .Remaining(rem_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_done, e_busy, e_rem;
    for (int i = 0; i < 2; i++) begin
      if (!armed[i]) begin
        e_done = 0; e_busy = 0; e_rem = 0;
      end else begin
        e_done = (elapsed[i] >= counts[i]) ? 1 : 0;
        e_busy = (elapsed[i] <  counts[i]) ? 1 : 0;
        e_rem  = (elapsed[i] <  counts[i]) ? 32'(counts[i] - elapsed[i]) : 0;
      end
      if (i == 0) begin
        chk("done300", {31'b0, done_a}, e_done);
        chk("busy300", {31'b0, busy_a}, e_busy);
        chk("rem300",  {23'b0, rem_a},  e_rem);
      end else begin
        chk("done1", {31'b0, done_b}, e_done);
        chk("busy1", {31'b0, busy_b}, e_busy);
        chk("rem1",  {31'b0, rem_b},  e_rem);
      end
    end
  endtask

  task automatic step(input bit rst, input bit st);
    Reset = rst;
    Start = st;
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        armed[i] = 1'b0;
        elapsed[i] = 0;
      end else if (st) begin
        armed[i] = 1'b1;
        elapsed[i] = 0;
      end else if (armed[i] && elapsed[i] < 100000) begin
        elapsed[i]++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    // Reset with Start high
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    idle_cycles(3);

    // Nominal: 5-cycle Start, then full count plus 50 cycles of held Done
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    idle_cycles(350);

    // Retrigger mid-run, then retrigger from DONE
    step(1'b0, 1'b1);
    idle_cycles(150);
    step(1'b0, 1'b1);
    idle_cycles(305);
    step(1'b0, 1'b1);
    idle_cycles(305);

    // Reset mid-count, then fresh start
    step(1'b0, 1'b1);
    idle_cycles(100);
    step(1'b1, 1'b0);
    idle_cycles(320);
    step(1'b0, 1'b1);
    idle_cycles(305);

    // Reset and Start together; then a long Start hold
    step(1'b0, 1'b1);
    idle_cycles(10);
    step(1'b1, 1'b1);
    idle_cycles(3);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);
    idle_cycles(305);

    // Randomized pulses, gaps and occasional resets
    for (int seg = 0; seg < 25; seg++) begin
      int hold, gap;
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(1, 400);
      for (int i = 0; i < hold; i++) step($urandom_range(0, 15) == 0, 1'b1);
      for (int i = 0; i < gap; i++) step($urandom_range(0, 299) == 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
